// File: rtl/vend_credit_seq.sv
//------------------------------------------------------------------------------
// vend_credit_seq
// Owns the vending machine credit register. Runs coin, buy, query and refund
// commands through an external shared 5-bit ALU and reports each result over
// a valid/ready response channel.
//
// Optional feature (macro VEND_AUTOREFUND_EN): an idle counter that refunds
// held credit after TIMEOUT_CYCLES quiet cycles in IDLE. Without the macro
// there is no counter and credit persists indefinitely.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_code, cmd_data        00 COIN, 01 BUY, 10 QUERY, 11 REFUND; coin/price
//   alu_a, alu_b, alu_op      ALU operands/opcode (00 add 01 sub 10 and 11 or)
//   alu_result, alu_carry,
//   alu_zero, alu_negative    combinational ALU result and flags
//   rsp_valid/rsp_ready       response handshake
//   rsp_status                00 OK, 01 ERR_OVF, 10 ERR_FUNDS, 11 EMPTY
//   rsp_credit, rsp_flags     credit after the command, {carry, zero, negative}
//   vend_pulse                one-cycle pulse on a successful BUY
//   change_valid, change_amt  one-cycle refund pulse and its amount
//------------------------------------------------------------------------------
module vend_credit_seq #(
   parameter int MAX_CREDIT = 31
`ifdef VEND_AUTOREFUND_EN
   ,
   parameter int TIMEOUT_CYCLES = 1000
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_code,
   input  logic [4:0] cmd_data,
   output logic [4:0] alu_a,
   output logic [4:0] alu_b,
   output logic [1:0] alu_op,
   input  logic [4:0] alu_result,
   input  logic       alu_carry,
   input  logic       alu_zero,
   input  logic       alu_negative,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [1:0] rsp_status,
   output logic [4:0] rsp_credit,
   output logic [2:0] rsp_flags,
   output logic       vend_pulse,
   output logic       change_valid,
   output logic [4:0] change_amt
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2} state_t;

   localparam logic [1:0] CMD_COIN   = 2'b00;
   localparam logic [1:0] CMD_BUY    = 2'b01;
   localparam logic [1:0] CMD_QUERY  = 2'b10;
   localparam logic [1:0] CMD_REFUND = 2'b11;

   localparam logic [1:0] STS_OK     = 2'b00;
   localparam logic [1:0] STS_OVF    = 2'b01;
   localparam logic [1:0] STS_FUNDS  = 2'b10;
   localparam logic [1:0] STS_EMPTY  = 2'b11;

   // Compared against {carry, result} so any carry-out also counts as overflow.
   localparam logic [5:0] MAX_W = 6'(MAX_CREDIT);

   state_t     state_r, state_s;
   logic [1:0] code_r, code_s;
   logic [4:0] data_r, data_s;
   logic [4:0] credit_r, credit_s;
   logic       cmd_ready_r, cmd_ready_s;
   logic [4:0] alu_a_r, alu_a_s, alu_b_r, alu_b_s;
   logic [1:0] alu_op_r, alu_op_s;
   logic       rsp_valid_r, rsp_valid_s;
   logic [1:0] rsp_status_r, rsp_status_s;
   logic [4:0] rsp_credit_r, rsp_credit_s;
   logic [2:0] rsp_flags_r, rsp_flags_s;
   logic       vend_pulse_r, vend_pulse_s;
   logic       change_valid_r, change_valid_s;
   logic [4:0] change_amt_r, change_amt_s;
   logic       hs_s;
   logic       fire_s;
   logic       ready_block_s;

   assign hs_s = (state_r == ST_IDLE) && cmd_valid && cmd_ready_r;

`ifdef VEND_AUTOREFUND_EN
   localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);
   logic [15:0] idle_cnt_r, idle_cnt_s;

   // Idle counter next value: counts quiet IDLE cycles while credit is held.
   always_comb begin
      idle_cnt_s = 16'd0;
      if ((state_r == ST_IDLE) && (credit_r != 5'd0) && !hs_s && !fire_s) begin
         idle_cnt_s = idle_cnt_r + 16'd1;
      end else begin
         idle_cnt_s = 16'd0;
      end
   end

   // Idle counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_r <= 16'd0;
      end else begin
         idle_cnt_r <= idle_cnt_s;
      end
   end

   assign fire_s        = (state_r == ST_IDLE) && (idle_cnt_r == TIMEOUT_W);
   // cmd_ready is registered, so it must already be low in the cycle that fires.
   assign ready_block_s = (idle_cnt_s == TIMEOUT_W);
`else
   assign fire_s        = 1'b0;
   assign ready_block_s = 1'b0;
`endif

   // Next state, latched command and ALU drive.
   always_comb begin
      state_s  = state_r;
      code_s   = code_r;
      data_s   = data_r;
      alu_a_s  = 5'd0;
      alu_b_s  = 5'd0;
      alu_op_s = 2'b00;
      case (state_r)
         ST_IDLE: begin
            if (fire_s) begin
               code_s  = CMD_REFUND;
               data_s  = 5'd0;
               state_s = ST_EXEC;
            end else if (hs_s) begin
               code_s  = cmd_code;
               data_s  = cmd_data;
               state_s = ST_EXEC;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_EXEC: state_s = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: state_s = ST_IDLE;
      endcase
      // ALU outputs are registered, so they are loaded on the way into EXEC.
      if (state_s == ST_EXEC) begin
         alu_a_s  = credit_r;
         alu_op_s = code_s;
         case (code_s)
            CMD_COIN:  alu_b_s = data_s;
            CMD_BUY:   alu_b_s = data_s;
            CMD_QUERY: alu_b_s = 5'h1F;
            default:   alu_b_s = 5'd0;
         endcase
      end else begin
         alu_a_s  = 5'd0;
      end
   end

   // Command evaluation from ALU flags and response/pulse next values.
   always_comb begin
      credit_s       = credit_r;
      rsp_status_s   = rsp_status_r;
      rsp_flags_s    = rsp_flags_r;
      rsp_credit_s   = rsp_credit_r;
      vend_pulse_s   = 1'b0;
      change_valid_s = 1'b0;
      change_amt_s   = change_amt_r;
      if (state_r == ST_EXEC) begin
         rsp_flags_s = {alu_carry, alu_zero, alu_negative};
         case (code_r)
            CMD_COIN: begin
               if ({alu_carry, alu_result} > MAX_W) begin
                  rsp_status_s = STS_OVF;
               end else begin
                  credit_s     = alu_result;
                  rsp_status_s = STS_OK;
               end
            end
            CMD_BUY: begin
               if (alu_carry) begin
                  rsp_status_s = STS_FUNDS;
               end else begin
                  credit_s     = alu_result;
                  rsp_status_s = STS_OK;
                  vend_pulse_s = 1'b1;
               end
            end
            CMD_QUERY: rsp_status_s = STS_OK;
            CMD_REFUND: begin
               if (alu_zero) begin
                  rsp_status_s = STS_EMPTY;
               end else begin
                  change_amt_s   = alu_result;
                  change_valid_s = 1'b1;
                  credit_s       = 5'd0;
                  rsp_status_s   = STS_OK;
               end
            end
            default: rsp_status_s = STS_OK;
         endcase
         rsp_credit_s = credit_s;
      end else begin
         rsp_credit_s = rsp_credit_r;
      end
      rsp_valid_s = (state_s == ST_RESP);
      cmd_ready_s = (state_s == ST_IDLE) && !ready_block_s;
   end

   // State, credit and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         code_r         <= 2'b00;
         data_r         <= 5'd0;
         credit_r       <= 5'd0;
         cmd_ready_r    <= 1'b0;
         alu_a_r        <= 5'd0;
         alu_b_r        <= 5'd0;
         alu_op_r       <= 2'b00;
         rsp_valid_r    <= 1'b0;
         rsp_status_r   <= 2'b00;
         rsp_credit_r   <= 5'd0;
         rsp_flags_r    <= 3'b000;
         vend_pulse_r   <= 1'b0;
         change_valid_r <= 1'b0;
         change_amt_r   <= 5'd0;
      end else begin
         state_r        <= state_s;
         code_r         <= code_s;
         data_r         <= data_s;
         credit_r       <= credit_s;
         cmd_ready_r    <= cmd_ready_s;
         alu_a_r        <= alu_a_s;
         alu_b_r        <= alu_b_s;
         alu_op_r       <= alu_op_s;
         rsp_valid_r    <= rsp_valid_s;
         rsp_status_r   <= rsp_status_s;
         rsp_credit_r   <= rsp_credit_s;
         rsp_flags_r    <= rsp_flags_s;
         vend_pulse_r   <= vend_pulse_s;
         change_valid_r <= change_valid_s;
         change_amt_r   <= change_amt_s;
      end
   end

   assign cmd_ready    = cmd_ready_r;
   assign alu_a        = alu_a_r;
   assign alu_b        = alu_b_r;
   assign alu_op       = alu_op_r;
   assign rsp_valid    = rsp_valid_r;
   assign rsp_status   = rsp_status_r;
   assign rsp_credit   = rsp_credit_r;
   assign rsp_flags    = rsp_flags_r;
   assign vend_pulse   = vend_pulse_r;
   assign change_valid = change_valid_r;
   assign change_amt   = change_amt_r;

endmodule

// File: tb/tb_vend_credit_seq.sv
//------------------------------------------------------------------------------
// tb_vend_credit_seq
// Two sequencers share one command/response stimulus: one with MAX_CREDIT=31,
// one with MAX_CREDIT=20. Each has its own behavioural ALU. Expected results
// come from an arithmetic credit model per instance.
//------------------------------------------------------------------------------
module tb_vend_credit_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic [1:0] cmd_code;
   logic [4:0] cmd_data;
   logic       rsp_ready;

   logic       cmd_ready_w    [2];
   logic [4:0] alu_a_w        [2];
   logic [4:0] alu_b_w        [2];
   logic [1:0] alu_op_w       [2];
   logic [4:0] alu_result_w   [2];
   logic       alu_carry_w    [2];
   logic       alu_zero_w     [2];
   logic       alu_negative_w [2];
   logic       rsp_valid_w    [2];
   logic [1:0] rsp_status_w   [2];
   logic [4:0] rsp_credit_w   [2];
   logic [2:0] rsp_flags_w    [2];
   logic       vend_pulse_w   [2];
   logic       change_valid_w [2];
   logic [4:0] change_amt_w   [2];

   int n_total = 0;
   int n_pass  = 0;

   int m_credit   [2];
   int exp_status [2];
   int exp_flags  [2];
   int exp_vend   [2];
   int exp_chg    [2];
   int exp_amt    [2];
   int exp_alu_a  [2];
   int exp_alu_b;
   int exp_alu_op;

   always #5 clk = ~clk;

   // Shared ALU behaviour: {carry/borrow, result}.
   function automatic logic [5:0] alu_calc(input logic [4:0] a, input logic [4:0] b,
                                           input logic [1:0] op);
      case (op)
         2'b00:   return {1'b0, a} + {1'b0, b};
         2'b01:   return {1'b0, a} - {1'b0, b};
         2'b10:   return {1'b0, a & b};
         default: return {1'b0, a | b};
      endcase
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      assign {alu_carry_w[g], alu_result_w[g]} = alu_calc(alu_a_w[g], alu_b_w[g], alu_op_w[g]);
      assign alu_zero_w[g]     = (alu_result_w[g] == 5'd0);
      assign alu_negative_w[g] = alu_result_w[g][4];

      vend_credit_seq #(.MAX_CREDIT(g == 0 ? 31 : 20)) u_dut (
         .clk          (clk),
         .rst          (rst),
         .cmd_valid    (cmd_valid),
         .cmd_ready    (cmd_ready_w[g]),
         .cmd_code     (cmd_code),
         .cmd_data     (cmd_data),
         .alu_a        (alu_a_w[g]),
         .alu_b        (alu_b_w[g]),
         .alu_op       (alu_op_w[g]),
         .alu_result   (alu_result_w[g]),
         .alu_carry    (alu_carry_w[g]),
         .alu_zero     (alu_zero_w[g]),
         .alu_negative (alu_negative_w[g]),
         .rsp_valid    (rsp_valid_w[g]),
         .rsp_ready    (rsp_ready),
         .rsp_status   (rsp_status_w[g]),
         .rsp_credit   (rsp_credit_w[g]),
         .rsp_flags    (rsp_flags_w[g]),
         .vend_pulse   (vend_pulse_w[g]),
         .change_valid (change_valid_w[g]),
         .change_amt   (change_amt_w[g])
      );
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: credit arithmetic straight from the command rules.
   task automatic model_step(input logic [1:0] code, input logic [4:0] data);
      exp_alu_op = int'(code);
      exp_alu_b  = (code == 2'b10) ? 31 : (code == 2'b11) ? 0 : int'(data);
      for (int k = 0; k < 2; k++) begin
         int c, r, rr, cy, mx;
         c  = m_credit[k];
         mx = (k == 0) ? 31 : 20;
         cy = 0;
         rr = 0;
         exp_alu_a[k] = c;
         exp_vend[k]  = 0;
         exp_chg[k]   = 0;
         case (code)
            2'b00: begin
               r  = c + int'(data);
               cy = (r > 31) ? 1 : 0;
               rr = r % 32;
               if (r > mx) exp_status[k] = 1;
               else begin exp_status[k] = 0; c = r; end
            end
            2'b01: begin
               r  = c - int'(data);
               cy = (r < 0) ? 1 : 0;
               rr = (r + 32) % 32;
               if (r < 0) exp_status[k] = 2;
               else begin exp_status[k] = 0; c = r; exp_vend[k] = 1; end
            end
            2'b10: begin
               rr = c;
               exp_status[k] = 0;
            end
            default: begin
               rr = c;
               if (c == 0) exp_status[k] = 3;
               else begin exp_status[k] = 0; exp_chg[k] = 1; exp_amt[k] = c; c = 0; end
            end
         endcase
         exp_flags[k] = cy * 4 + ((rr == 0) ? 2 : 0) + ((rr >= 16) ? 1 : 0);
         m_credit[k]  = c;
      end
   endtask

   task automatic check_resp(input bit first);
      for (int k = 0; k < 2; k++) begin
         check_eq($sformatf("rsp_valid%0d", k), 32'(rsp_valid_w[k]), 32'd1);
         check_eq($sformatf("busy_ready%0d", k), 32'(cmd_ready_w[k]), 32'd0);
         check_eq($sformatf("status%0d", k), 32'(rsp_status_w[k]), exp_status[k]);
         check_eq($sformatf("credit%0d", k), 32'(rsp_credit_w[k]), m_credit[k]);
         check_eq($sformatf("flags%0d", k), 32'(rsp_flags_w[k]), exp_flags[k]);
         check_eq($sformatf("vend%0d", k), 32'(vend_pulse_w[k]), first ? exp_vend[k] : 0);
         check_eq($sformatf("chg_valid%0d", k), 32'(change_valid_w[k]), first ? exp_chg[k] : 0);
         if (first && exp_chg[k] != 0) begin
            check_eq($sformatf("chg_amt%0d", k), 32'(change_amt_w[k]), exp_amt[k]);
         end
         check_eq($sformatf("alu_idle%0d", k), {alu_a_w[k], alu_b_w[k], alu_op_w[k]}, 32'd0);
      end
   endtask

   task automatic do_cmd(input logic [1:0] code, input logic [4:0] data, input int stall);
      int n;
      n         = 0;
      cmd_valid = 1'b1;
      cmd_code  = code;
      cmd_data  = data;
      rsp_ready = 1'b0;
      while (!cmd_ready_w[0] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("accept_wait", 32'(n < 20), 32'd1);
      model_step(code, data);
      @(posedge clk); #1;
      // Busy: keep cmd_valid high with unrelated contents; it must be ignored.
      cmd_code = 2'($urandom_range(0, 3));
      cmd_data = 5'($urandom_range(0, 31));
      for (int k = 0; k < 2; k++) begin
         check_eq($sformatf("exec_ready%0d", k), 32'(cmd_ready_w[k]), 32'd0);
         check_eq($sformatf("exec_valid%0d", k), 32'(rsp_valid_w[k]), 32'd0);
         check_eq($sformatf("alu_op%0d", k), 32'(alu_op_w[k]), exp_alu_op);
         check_eq($sformatf("alu_a%0d", k), 32'(alu_a_w[k]), exp_alu_a[k]);
         check_eq($sformatf("alu_b%0d", k), 32'(alu_b_w[k]), exp_alu_b);
      end
      @(posedge clk); #1;
      check_resp(1'b1);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check_resp(1'b0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check_eq($sformatf("idle_valid%0d", k), 32'(rsp_valid_w[k]), 32'd0);
         check_eq($sformatf("idle_ready%0d", k), 32'(cmd_ready_w[k]), 32'd1);
         check_eq($sformatf("held_status%0d", k), 32'(rsp_status_w[k]), exp_status[k]);
         check_eq($sformatf("held_credit%0d", k), 32'(rsp_credit_w[k]), m_credit[k]);
         check_eq($sformatf("idle_pulses%0d", k), {vend_pulse_w[k], change_valid_w[k]}, 32'd0);
      end
   endtask

   task automatic reset_in_exec();
      int n;
      n         = 0;
      cmd_valid = 1'b1;
      cmd_code  = 2'b00;
      cmd_data  = 5'd5;
      while (!cmd_ready_w[0] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("rst_accept_wait", 32'(n < 20), 32'd1);
      @(posedge clk); #1;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_credit[k]   = 0;
         exp_status[k] = 0;
         check_eq($sformatf("abort_valid%0d", k), 32'(rsp_valid_w[k]), 32'd0);
         check_eq($sformatf("abort_credit%0d", k), 32'(rsp_credit_w[k]), 32'd0);
         check_eq($sformatf("abort_chg%0d", k), 32'(change_valid_w[k]), 32'd0);
         check_eq($sformatf("abort_ready%0d", k), 32'(cmd_ready_w[k]), 32'd0);
      end
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         check_eq($sformatf("post_rst_ready%0d", k), 32'(cmd_ready_w[k]), 32'd1);
      end
   endtask

   // Directed sequence: {code, data, stall cycles}.
   localparam int N_DIR = 16;
   logic [1:0] dir_code  [N_DIR] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd3, 2'd0,
                                     2'd1, 2'd1, 2'd0, 2'd3, 2'd3, 2'd0, 2'd2, 2'd1};
   logic [4:0] dir_data  [N_DIR] = '{5'd10, 5'd15, 5'd10, 5'd0, 5'd15, 5'd6, 5'd0, 5'd12,
                                     5'd12, 5'd1, 5'd9, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0};
   int         dir_stall [N_DIR] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0};

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_code  = 2'b00;
      cmd_data  = 5'd0;
      rsp_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_credit[k] = 0; exp_status[k] = 0; exp_flags[k] = 0;
         exp_vend[k] = 0; exp_chg[k] = 0; exp_amt[k] = 0; exp_alu_a[k] = 0;
      end
      exp_alu_b  = 0;
      exp_alu_op = 0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         check_eq($sformatf("rst_ready%0d", k), 32'(cmd_ready_w[k]), 32'd0);
         check_eq($sformatf("rst_valid%0d", k), 32'(rsp_valid_w[k]), 32'd0);
         check_eq($sformatf("rst_rsp%0d", k), {rsp_status_w[k], rsp_credit_w[k], rsp_flags_w[k]}, 32'd0);
         check_eq($sformatf("rst_pulses%0d", k), {vend_pulse_w[k], change_valid_w[k], change_amt_w[k]}, 32'd0);
         check_eq($sformatf("rst_alu%0d", k), {alu_a_w[k], alu_b_w[k], alu_op_w[k]}, 32'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         check_eq($sformatf("first_ready%0d", k), 32'(cmd_ready_w[k]), 32'd1);
      end

      for (int i = 0; i < N_DIR; i++) begin
         do_cmd(dir_code[i], dir_data[i], dir_stall[i]);
      end

      reset_in_exec();

      for (int i = 0; i < 150; i++) begin
         do_cmd(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end

endmodule
